// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared state encodings and word/block defaults for the receive path
package receiver_pkg;

    localparam int WORD_BITS_DEF   = 16;
    localparam int BLOCK_WORDS_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_t;

    // Next block index, wrapping at the block size rather than at a power of two.
    function automatic int next_word_index(input int idx, input int block_words);
        return (idx == block_words - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bit_sampler.sv
// rtl/bit_sampler.sv - line synchroniser, start-edge detect and mid-bit sample tick
module bit_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic Reset,
    input  logic serial_in,
    input  logic restart,
    input  logic half_bit,
    output logic rx_s,
    output logic fall,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1;
    logic          rx_prev;
    logic [CW-1:0] cnt;

    // Synchroniser and edge-history flops reset to the idle-line level so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            cnt     <= '0;
        end else begin
            sync1   <= serial_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
            if (restart || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign tick = !restart && (cnt == (half_bit ? HALF_T : FULL_T));

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - one-wire word deserialiser with parity, stop check and block marking
module serial_receiver
    import receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_BITS    = WORD_BITS_DEF,
    parameter int BLOCK_WORDS  = BLOCK_WORDS_DEF,
    parameter int PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 SerialIn,
    output logic [WORD_BITS-1:0] rcvDataOut,
    output logic                 Ack,
    output logic                 Ready,
    output logic                 FrameError
);

    localparam int BW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int WC_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [BW-1:0]   LAST_BIT  = BW'(WORD_BITS - 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(BLOCK_WORDS - 1);

    rx_state_t            state;
    logic [BW-1:0]        bit_idx;
    logic [WORD_BITS-1:0] shreg;
    logic                 parity_ok;
    logic [WC_W-1:0]      word_count;

    logic rx_s;
    logic fall;
    logic tick;
    logic restart;
    logic half_bit;
    logic stop_good;

    // The sample counter free-runs only while a frame is in progress; holding it
    // cleared in IDLE aligns the first half-bit count to the detected edge.
    assign restart  = (state == IDLE);
    assign half_bit = (state == START);

    bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_sampler (
        .clk      (clk),
        .Reset    (Reset),
        .serial_in(SerialIn),
        .restart  (restart),
        .half_bit (half_bit),
        .rx_s     (rx_s),
        .fall     (fall),
        .tick     (tick)
    );

    assign stop_good = rx_s && (parity_ok || (PARITY_EN == 0));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_ok  <= 1'b0;
            word_count <= '0;
            rcvDataOut <= '0;
            Ack        <= 1'b0;
            Ready      <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            Ack        <= 1'b0;
            FrameError <= 1'b0;
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (fall) begin
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        parity_ok <= ~(^shreg ^ rx_s);
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_good) begin
                            Ack        <= 1'b1;
                            rcvDataOut <= shreg;
                            Ready      <= (word_count == LAST_WORD);
                            word_count <= WC_W'(next_word_index(int'(word_count), BLOCK_WORDS));
                        end else begin
                            FrameError <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - directed bench for serial_receiver
module tb_serial_receiver;

    localparam int CPB = 4;

    logic        clk;
    logic        Reset;
    logic        SerialIn;
    logic [15:0] rcvDataOut;
    logic        Ack;
    logic        Ready;
    logic        FrameError;

    int n_checks;
    int n_errors;
    int ack_cnt;
    int fe_cnt;
    int both_cnt;
    int wide_cnt;
    logic        ack_prev;
    logic [15:0] last_data;
    logic        last_ready;

    serial_receiver #(
        .CLKS_PER_BIT(CPB),
        .WORD_BITS   (16),
        .BLOCK_WORDS (16),
        .PARITY_EN   (1)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .SerialIn  (SerialIn),
        .rcvDataOut(rcvDataOut),
        .Ack       (Ack),
        .Ready     (Ready),
        .FrameError(FrameError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Ack) begin
            ack_cnt++;
            last_data  = rcvDataOut;
            last_ready = Ready;
        end
        if (FrameError) fe_cnt++;
        if (Ack && FrameError) both_cnt++;
        if (Ack && ack_prev) wide_cnt++;
        ack_prev = Ack;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int cycles);
        SerialIn = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] data, input logic flip_par,
                             input logic stop_val, input int stop_cycles);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 16; i++) drive_bit(data[i], CPB);
        drive_bit((^data) ^ flip_par, CPB);
        drive_bit(stop_val, stop_cycles);
        SerialIn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a0;
        int f0;
        logic [15:0] w;
        n_checks = 0; n_errors = 0;
        ack_cnt = 0; fe_cnt = 0; both_cnt = 0; wide_cnt = 0;
        ack_prev = 1'b0; last_data = '0; last_ready = 1'b0;
        SerialIn = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", rcvDataOut, 16'h0000);
        check("reset_ack", Ack, 0);
        check("reset_ready", Ready, 0);
        check("reset_fe", FrameError, 0);
        Reset = 1'b0;
        repeat (3) @(negedge clk);

        send_word(16'hA5C3, 1'b0, 1'b1, CPB);
        check("a5c3_acks", ack_cnt, 1);
        check("a5c3_data", last_data, 16'hA5C3);
        check("a5c3_ready", last_ready, 0);
        check("a5c3_fe", fe_cnt, 0);

        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            a0 = ack_cnt;
            send_word(16'(i), 1'b0, 1'b1, CPB);
            check("blk_ack", ack_cnt - a0, 1);
            check("blk_data", last_data, 32'(i));
            check("blk_ready", last_ready, (i == 15) ? 1 : 0);
        end

        send_word(16'h1234, 1'b0, 1'b1, CPB);
        check("wrap_data", last_data, 16'h1234);
        check("wrap_ready", last_ready, 0);

        a0 = ack_cnt; f0 = fe_cnt;
        send_word(16'h0001, 1'b1, 1'b1, CPB);
        check("par_fe", fe_cnt - f0, 1);
        check("par_noack", ack_cnt - a0, 0);
        check("par_data_held", rcvDataOut, 16'h1234);
        check("par_count_held", dut.word_count, 1);

        a0 = ack_cnt; f0 = fe_cnt;
        send_word(16'hFFFF, 1'b0, 1'b0, 40);
        check("break_fe", fe_cnt - f0, 1);
        check("break_noack", ack_cnt - a0, 0);
        send_word(16'h00FF, 1'b0, 1'b1, CPB);
        check("after_break_ack", ack_cnt - a0, 1);
        check("after_break_data", last_data, 16'h00FF);
        check("after_break_ready", last_ready, 0);

        a0 = ack_cnt; f0 = fe_cnt;
        SerialIn = 1'b0;
        @(negedge clk);
        SerialIn = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_noack", ack_cnt - a0, 0);
        check("glitch_nofe", fe_cnt - f0, 0);
        check("glitch_idle", dut.state, 0);

        w = 16'hBEEF;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 7; i++) drive_bit(w[i], CPB);
        SerialIn = w[7];
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        #1;
        check("midrst_data", rcvDataOut, 16'h0000);
        check("midrst_ack", Ack, 0);
        check("midrst_ready", Ready, 0);
        check("midrst_fe", FrameError, 0);
        check("midrst_count", dut.word_count, 0);
        repeat (2) @(negedge clk);
        Reset = 1'b0;
        SerialIn = 1'b1;
        repeat (8) @(negedge clk);
        a0 = ack_cnt;
        send_word(16'h1111, 1'b0, 1'b1, CPB);
        check("post_rst_ack", ack_cnt - a0, 1);
        check("post_rst_data", last_data, 16'h1111);
        check("post_rst_ready", last_ready, 0);

        check("ack_fe_overlap", both_cnt, 0);
        check("ack_width", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
